car_request_sensor: RTL and testbench

Sensor front end for the intersection light controller. Takes raw, asynchronous, bouncy vehicle-loop inputs for the EW and NS approaches and produces clean, latched per-direction car requests (ew_car, ns_car) for the controller. It observes the controller's light outputs (ew_lite, ns_lite) to decide when a waiting car has been served. Once a request is set, it is held until that car's direction has actually had green.

---
 rtl/car_request_sensor.sv | 197 +++++++++++++++++++
 tb/tb_car_request_sensor.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/car_request_sensor.sv
// Vehicle-loop front end: two-flop sync, debounce, and a latched per-direction car request.
// Optional STARVE_ALARM_EN adds sticky ew_starve/ns_starve flags driven by the wait counters.

module car_request_channel #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SERVE_CYCLES    = 8,
    parameter int WAIT_W          = 8,
    parameter int MAX_WAIT        = 200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              loop_raw,
    input  logic              own_lite,
    output logic              car,
    output logic [WAIT_W-1:0] wait_cnt
`ifdef STARVE_ALARM_EN
    ,
    output logic              starve
`endif
);
    // state   | meaning
    // IDLE    | no outstanding request
    // REQ     | car waiting for own green, wait counter running
    // SERVING | own green active, serve counter running, wait held

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int SW = (SERVE_CYCLES > 1) ? $clog2(SERVE_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] SERVE_LAST = SW'(SERVE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVING = 2'd2
    } state_t;

    state_t            state, next_state;
    logic              sync1, sync2;
    logic              deb, deb_prev;
    logic [DW-1:0]     deb_cnt;
    logic [SW-1:0]     serve_cnt;
    logic [WAIT_W-1:0] wait_next;
    logic              arrival;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= loop_raw;
            sync2 <= sync1;
        end
    end

    // The level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb      <= 1'b0;
            deb_cnt  <= '0;
            deb_prev <= 1'b0;
        end else begin
            deb_prev <= deb;
            if (sync2 == deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb     <= ~deb;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    assign arrival = deb & ~deb_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (arrival && !own_lite) next_state = REQ;
            REQ:     if (own_lite) next_state = SERVING;
            SERVING: begin
                if (serve_cnt == SERVE_LAST && !deb) next_state = IDLE;
                else if (!own_lite)                  next_state = REQ;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        car = (state == REQ) || (state == SERVING);
    end

    // Held at zero outside SERVING so every service window starts from 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      serve_cnt <= '0;
        else if (state != SERVING)       serve_cnt <= '0;
        else if (serve_cnt != SERVE_LAST) serve_cnt <= serve_cnt + 1'b1;
    end

    always_comb begin
        wait_next = wait_cnt;
        if (next_state == IDLE)             wait_next = '0;
        else if (state == REQ && !(&wait_cnt)) wait_next = wait_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_cnt <= '0;
        else        wait_cnt <= wait_next;
    end

`ifdef STARVE_ALARM_EN
    localparam logic [WAIT_W-1:0] MAX_LVL = WAIT_W'(MAX_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    starve <= 1'b0;
        else if (next_state == IDLE)   starve <= 1'b0;
        else if (wait_next >= MAX_LVL) starve <= 1'b1;
    end
`endif

endmodule

module car_request_sensor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SERVE_CYCLES    = 8,
    parameter int WAIT_W          = 8,
    parameter int MAX_WAIT        = 200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ew_loop_raw,
    input  logic              ns_loop_raw,
    input  logic              ew_lite,
    input  logic              ns_lite,
    output logic              ew_car,
    output logic              ns_car,
    output logic [WAIT_W-1:0] ew_wait,
    output logic [WAIT_W-1:0] ns_wait
`ifdef STARVE_ALARM_EN
    ,
    output logic              ew_starve,
    output logic              ns_starve
`endif
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end
    if (SERVE_CYCLES < 1) begin : g_bad_serve
        $error("SERVE_CYCLES must be at least 1");
    end
    if (MAX_WAIT >= (1 << WAIT_W)) begin : g_bad_max_wait
        $error("MAX_WAIT must fit in WAIT_W bits");
    end

    car_request_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SERVE_CYCLES   (SERVE_CYCLES),
        .WAIT_W         (WAIT_W),
        .MAX_WAIT       (MAX_WAIT)
    ) u_ew (
        .clk     (clk),
        .rst_n   (rst_n),
        .loop_raw(ew_loop_raw),
        .own_lite(ew_lite),
        .car     (ew_car),
        .wait_cnt(ew_wait)
`ifdef STARVE_ALARM_EN
        ,
        .starve  (ew_starve)
`endif
    );

    car_request_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SERVE_CYCLES   (SERVE_CYCLES),
        .WAIT_W         (WAIT_W),
        .MAX_WAIT       (MAX_WAIT)
    ) u_ns (
        .clk     (clk),
        .rst_n   (rst_n),
        .loop_raw(ns_loop_raw),
        .own_lite(ns_lite),
        .car     (ns_car),
        .wait_cnt(ns_wait)
`ifdef STARVE_ALARM_EN
        ,
        .starve  (ns_starve)
`endif
    );

endmodule

// File: tb/tb_car_request_sensor.sv
// Bench for car_request_sensor: reset/latency table, hand-written corner sequences,
// then randomized bouncy loops and lights checked against a behavioural model.

module tb_car_request_sensor;
    localparam int D    = 4;
    localparam int S    = 8;
    localparam int W    = 8;
    localparam int MW   = 10;
    localparam int WMAX = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ew_loop_raw, ns_loop_raw, ew_lite, ns_lite;
    logic         ew_car, ns_car;
    logic [W-1:0] ew_wait, ns_wait;
`ifdef STARVE_ALARM_EN
    logic         ew_starve, ns_starve;
`endif

    car_request_sensor #(
        .DEBOUNCE_CYCLES(D),
        .SERVE_CYCLES   (S),
        .WAIT_W         (W),
        .MAX_WAIT       (MW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ew_loop_raw(ew_loop_raw),
        .ns_loop_raw(ns_loop_raw),
        .ew_lite    (ew_lite),
        .ns_lite    (ns_lite),
        .ew_car     (ew_car),
        .ns_car     (ns_car),
        .ew_wait    (ew_wait),
        .ns_wait    (ns_wait)
`ifdef STARVE_ALARM_EN
        ,
        .ew_starve  (ew_starve),
        .ns_starve  (ns_starve)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model per direction: raw delay line, disagreement run length, phase 0/1/2 =
    // idle / waiting / on green, cycles of green served, wait and starve values.
    int m_s1[2], m_s2[2], m_deb[2], m_prv[2], m_run[2];
    int m_ph[2], m_g[2], m_wt[2], m_stv[2];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_s1[c] = 0; m_s2[c] = 0; m_deb[c] = 0; m_prv[c] = 0; m_run[c] = 0;
            m_ph[c] = 0; m_g[c] = 0; m_wt[c] = 0; m_stv[c] = 0;
        end
    endtask

    task automatic model_edge(input int c, input int raw, input int lite);
        int arr, nd, nr;
        arr = (m_deb[c] == 1 && m_prv[c] == 0) ? 1 : 0;
        nd  = m_deb[c];
        nr  = 0;
        if (m_s2[c] != m_deb[c]) begin
            if (m_run[c] + 1 == D) nd = 1 - m_deb[c];
            else                   nr = m_run[c] + 1;
        end
        case (m_ph[c])
            0: if (arr == 1 && lite == 0) m_ph[c] = 1;
            1: begin
                if (m_wt[c] < WMAX) m_wt[c]++;
                if (lite != 0) begin m_ph[c] = 2; m_g[c] = 0; end
            end
            default: begin
                if (m_g[c] == S - 1 && m_deb[c] == 0) begin m_ph[c] = 0; m_wt[c] = 0; end
                else if (lite == 0)                    m_ph[c] = 1;
                else if (m_g[c] < S - 1)               m_g[c]++;
            end
        endcase
        if (m_ph[c] == 0)    m_stv[c] = 0;
        else if (m_wt[c] >= MW) m_stv[c] = 1;
        m_prv[c] = m_deb[c];
        m_deb[c] = nd;
        m_run[c] = nr;
        m_s2[c]  = m_s1[c];
        m_s1[c]  = raw;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0, int'(ew_loop_raw), int'(ew_lite));
        model_edge(1, int'(ns_loop_raw), int'(ns_lite));
        #1;
        check("model ew_car", int'(ew_car), int'(m_ph[0] != 0));
        check("model ns_car", int'(ns_car), int'(m_ph[1] != 0));
        check("model ew_wait", int'(ew_wait), m_wt[0]);
        check("model ns_wait", int'(ns_wait), m_wt[1]);
`ifdef STARVE_ALARM_EN
        check("model ew_starve", int'(ew_starve), m_stv[0]);
        check("model ns_starve", int'(ns_starve), m_stv[1]);
`endif
    endtask

    typedef struct {
        logic ew_raw, ns_raw, ew_lt, ns_lt;
        logic ew_c, ns_c;
        int   ew_w, ns_w;
    } vec_t;

    vec_t vt[10];

    int   lvl[2], bnc[2], lite_left[2], raw_v[2], lite_v[2];

    initial begin
        // edge i+1 after release: EW held high, NS a 3-cycle glitch, both lights red
        vt[0] = '{1, 1, 0, 0, 0, 0, 0, 0};
        vt[1] = '{1, 1, 0, 0, 0, 0, 0, 0};
        vt[2] = '{1, 1, 0, 0, 0, 0, 0, 0};
        vt[3] = '{1, 0, 0, 0, 0, 0, 0, 0};
        vt[4] = '{1, 0, 0, 0, 0, 0, 0, 0};
        vt[5] = '{1, 0, 0, 0, 0, 0, 0, 0};
        vt[6] = '{1, 0, 0, 0, 1, 0, 0, 0};
        vt[7] = '{1, 0, 0, 0, 1, 0, 1, 0};
        vt[8] = '{1, 0, 0, 0, 1, 0, 2, 0};
        vt[9] = '{1, 0, 0, 0, 1, 0, 3, 0};

        rst_n = 1'b0;
        ew_loop_raw = 1'b0; ns_loop_raw = 1'b0; ew_lite = 1'b0; ns_lite = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ew_car", int'(ew_car), 0);
        check("reset ns_car", int'(ns_car), 0);
        check("reset ew_wait", int'(ew_wait), 0);
        check("reset ns_wait", int'(ns_wait), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            ew_loop_raw = vt[i].ew_raw; ns_loop_raw = vt[i].ns_raw;
            ew_lite = vt[i].ew_lt; ns_lite = vt[i].ns_lt;
            step();
            check($sformatf("table[%0d] ew_car", i), int'(ew_car), int'(vt[i].ew_c));
            check($sformatf("table[%0d] ns_car", i), int'(ns_car), int'(vt[i].ns_c));
            check($sformatf("table[%0d] ew_wait", i), int'(ew_wait), vt[i].ew_w);
            check($sformatf("table[%0d] ns_wait", i), int'(ns_wait), vt[i].ns_w);
        end

        // short green pre-empted: wait holds, request kept
        ew_lite = 1'b1;
        step();
        check("preempt first green wait", int'(ew_wait), 4);
        repeat (4) step();
        check("preempt green car", int'(ew_car), 1);
        check("preempt green wait held", int'(ew_wait), 4);
        ew_lite = 1'b0;
        step();
        check("preempt back to req car", int'(ew_car), 1);
        check("preempt back to req wait", int'(ew_wait), 4);
        step();
        check("preempt wait resumes", int'(ew_wait), 5);

        // full service with car leaving during green
        ew_lite = 1'b1;
        step();
        ew_loop_raw = 1'b0;
        repeat (7) step();
        check("serve last cycle car", int'(ew_car), 1);
        step();
        check("serve retire car", int'(ew_car), 0);
        check("serve retire wait", int'(ew_wait), 0);
        step();
        ew_lite = 1'b0;
        check("serve idle car", int'(ew_car), 0);

        // NS arrives on its own green: no request, none later either
        ns_lite = 1'b1; ns_loop_raw = 1'b1;
        repeat (12) step();
        check("green arrival ns_car", int'(ns_car), 0);
        check("green arrival ns_wait", int'(ns_wait), 0);
        ns_lite = 1'b0;
        repeat (3) step();
        check("green arrival no rearm", int'(ns_car), 0);
        ns_loop_raw = 1'b0;
        repeat (8) step();

        // mid-cycle reset during a request
        ew_loop_raw = 1'b1;
        repeat (7) step();
        check("rearrive ew_car", int'(ew_car), 1);
        repeat (3) step();
        check("rearrive ew_wait", int'(ew_wait), 3);
        #2 rst_n = 1'b0;
        #1;
        check("async reset ew_car", int'(ew_car), 0);
        check("async reset ew_wait", int'(ew_wait), 0);
        model_reset();
        #2 rst_n = 1'b1;
        repeat (6) step();
        check("post reset edge6 car", int'(ew_car), 0);
        step();
        check("post reset edge7 car", int'(ew_car), 1);
        repeat (9) step();
        check("wait 9", int'(ew_wait), 9);
`ifdef STARVE_ALARM_EN
        check("starve below max", int'(ew_starve), 0);
`endif
        step();
        check("wait 10", int'(ew_wait), 10);
`ifdef STARVE_ALARM_EN
        check("starve at max", int'(ew_starve), 1);
`endif
        repeat (250) step();
        check("wait saturated", int'(ew_wait), WMAX);
`ifdef STARVE_ALARM_EN
        check("starve sticky", int'(ew_starve), 1);
`endif
        ew_loop_raw = 1'b0; ew_lite = 1'b1;
        repeat (20) step();
        check("saturated retire car", int'(ew_car), 0);
        check("saturated retire wait", int'(ew_wait), 0);
`ifdef STARVE_ALARM_EN
        check("starve cleared", int'(ew_starve), 0);
`endif
        ew_lite = 1'b0;

        // randomized bouncy loops and independent light patterns
        for (int c = 0; c < 2; c++) begin
            lvl[c] = 0; bnc[c] = 0; lite_left[c] = 0; lite_v[c] = 0; raw_v[c] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < 2; c++) begin
                if (bnc[c] > 0) begin
                    raw_v[c] = int'($urandom_range(1, 0));
                    bnc[c]--;
                end else if ($urandom_range(59, 0) == 0) begin
                    lvl[c] = 1 - lvl[c];
                    bnc[c] = int'($urandom_range(6, 0));
                    raw_v[c] = int'($urandom_range(1, 0));
                end else begin
                    raw_v[c] = lvl[c];
                end
                if (lite_left[c] == 0) begin
                    lite_v[c] = 1 - lite_v[c];
                    lite_left[c] = int'($urandom_range(25, 1));
                end
                lite_left[c]--;
            end
            ew_loop_raw = raw_v[0][0]; ns_loop_raw = raw_v[1][0];
            ew_lite = lite_v[0][0];    ns_lite = lite_v[1][0];
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
